poly_voice_alloc: RTL

- Polyphonic voice allocator between the MIDI decoder (note / noteOn / noteOff strobes) and the oscillator stack.
- Maps incoming note events onto VOICES oscillator slots: per-voice note register, gate and retrigger pulse.
- Generalises the current single-path synth top to N voices, with duplicate-note retrigger, oldest-voice stealing and all-notes-off.
- One event is processed per cycle; no backpressure is needed because MIDI byte rate is far below clk_i.

---
 rtl/poly_voice_alloc.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/poly_voice_alloc.sv
// Polyphonic voice allocator: maps note-on/off events onto VOICES oscillator slots
// with duplicate retrigger, oldest-voice stealing (or dropping) and all-notes-off.
module poly_voice_alloc #(
    parameter int unsigned VOICES    = 4,
    parameter int unsigned NOTE_BITS = 7,
    parameter bit          STEAL_EN  = 1'b1,
    localparam int unsigned AGE_BITS = $clog2(VOICES),
    localparam int unsigned CNT_BITS = $clog2(VOICES + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NOTE_BITS-1:0]          note_i,
    input  logic                          noteOn_i,
    input  logic                          noteOff_i,
    input  logic                          allOff_i,
    output logic [VOICES*NOTE_BITS-1:0]   voiceNotes_o,
    output logic [VOICES-1:0]             voiceGate_o,
    output logic [VOICES-1:0]             voiceTrig_o,
    output logic [CNT_BITS-1:0]           activeCount_o,
    output logic                          stealStrb_o,
    output logic                          dropStrb_o
);

    logic [VOICES-1:0][NOTE_BITS-1:0] note_q, note_d;
    logic [VOICES-1:0][AGE_BITS-1:0]  age_q,  age_d;
    logic [VOICES-1:0]                gate_q, gate_d;
    logic [VOICES-1:0]                trig_q, trig_d;
    logic [CNT_BITS-1:0]              cnt_q,  cnt_d;
    logic                             steal_q, steal_d;
    logic                             drop_q,  drop_d;

    logic                hit_vld, free_vld, touch;
    logic [AGE_BITS-1:0] hit_idx, free_idx, old_idx, tgt_idx;

    // Lookups on the pre-edge state: gated voice holding note_i, lowest free voice, oldest voice.
    always_comb begin
        hit_vld  = 1'b0;
        hit_idx  = '0;
        free_vld = 1'b0;
        free_idx = '0;
        old_idx  = '0;
        for (int unsigned v = 0; v < VOICES; v++) begin
            if (!hit_vld && gate_q[v] && (note_q[v] == note_i)) begin
                hit_vld = 1'b1;
                hit_idx = AGE_BITS'(v);
            end
            if (!free_vld && !gate_q[v]) begin
                free_vld = 1'b1;
                free_idx = AGE_BITS'(v);
            end
            if (age_q[v] == AGE_BITS'(VOICES - 1)) begin
                old_idx = AGE_BITS'(v);
            end
        end
    end

    // Next state: noteOff is applied first so a same-note noteOn re-gates the voice.
    always_comb begin
        note_d  = note_q;
        age_d   = age_q;
        gate_d  = gate_q;
        trig_d  = '0;
        steal_d = 1'b0;
        drop_d  = 1'b0;
        touch   = 1'b0;
        tgt_idx = '0;
        cnt_d   = '0;

        if (allOff_i) begin
            gate_d = '0;
        end else begin
            if (noteOff_i && hit_vld) begin
                gate_d[hit_idx] = 1'b0;
            end
            if (noteOn_i) begin
                if (hit_vld) begin
                    touch   = 1'b1;
                    tgt_idx = hit_idx;
                end else if (free_vld) begin
                    touch            = 1'b1;
                    tgt_idx          = free_idx;
                    note_d[free_idx] = note_i;
                end else if (STEAL_EN) begin
                    touch           = 1'b1;
                    tgt_idx         = old_idx;
                    note_d[old_idx] = note_i;
                    steal_d         = 1'b1;
                end else begin
                    drop_d = 1'b1;
                end
            end
        end

        // Touched voice becomes youngest; voices younger than it age by one.
        if (touch) begin
            gate_d[tgt_idx] = 1'b1;
            trig_d[tgt_idx] = 1'b1;
            for (int unsigned v = 0; v < VOICES; v++) begin
                if (age_q[v] < age_q[tgt_idx]) begin
                    age_d[v] = age_q[v] + 1'b1;
                end
            end
            age_d[tgt_idx] = '0;
        end

        for (int unsigned v = 0; v < VOICES; v++) begin
            cnt_d = cnt_d + CNT_BITS'(gate_d[v]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            note_q  <= '0;
            gate_q  <= '0;
            trig_q  <= '0;
            cnt_q   <= '0;
            steal_q <= 1'b0;
            drop_q  <= 1'b0;
            for (int unsigned v = 0; v < VOICES; v++) begin
                age_q[v] <= AGE_BITS'(v);
            end
        end else begin
            note_q  <= note_d;
            age_q   <= age_d;
            gate_q  <= gate_d;
            trig_q  <= trig_d;
            cnt_q   <= cnt_d;
            steal_q <= steal_d;
            drop_q  <= drop_d;
        end
    end

    assign voiceNotes_o  = note_q;
    assign voiceGate_o   = gate_q;
    assign voiceTrig_o   = trig_q;
    assign activeCount_o = cnt_q;
    assign stealStrb_o   = steal_q;
    assign dropStrb_o    = drop_q;

endmodule
